// File: rtl/truth_table_sweeper.sv
// Drives every input combination of a small combinational circuit in ascending order,
// holds each one for DWELL cycles and captures the circuit's Y output into a truth table.
module truth_table_sweeper #(
    parameter int N_IN  = 3,
    parameter int DWELL = 20
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_y_in,
    output logic [N_IN-1:0]      o_abc,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2**N_IN-1:0]   o_table_out,
    output logic                 o_table_valid
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int NPAT = 2**N_IN;
    localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL - 1);
    localparam logic [N_IN-1:0] LAST_PAT = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_IN-1:0]   r_pattern;
    logic [N_IN-1:0]   w_pattern_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [N_IN-1:0]   r_abc;
    logic [N_IN-1:0]   w_abc_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic [NPAT-1:0]   r_table;
    logic [NPAT-1:0]   w_table_nxt;
    logic              r_valid;
    logic              w_valid_nxt;

    // Output registers are loaded with the values belonging to the state being entered,
    // so abc/busy/done line up exactly with the FSM state they describe.
    always_comb begin
        w_state_nxt   = r_state;
        w_pattern_nxt = r_pattern;
        w_cnt_nxt     = r_cnt;
        w_abc_nxt     = '0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_table_nxt   = r_table;
        w_valid_nxt   = r_valid;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt   = S_DRIVE;
                    w_pattern_nxt = '0;
                    w_cnt_nxt     = '0;
                    w_table_nxt   = '0;
                    w_valid_nxt   = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_abc_nxt     = '0;
                end
            end
            S_DRIVE: begin
                w_busy_nxt = 1'b1;
                w_abc_nxt  = r_pattern;
                w_cnt_nxt  = r_cnt + 1'b1;
                // Last dwell cycle is the only sample point for this pattern.
                if (r_cnt == LAST_CNT) begin
                    w_table_nxt[r_pattern] = i_y_in;
                    w_cnt_nxt              = '0;
                    if (r_pattern == LAST_PAT) begin
                        w_state_nxt = S_DONE;
                        w_busy_nxt  = 1'b0;
                        w_abc_nxt   = '0;
                        w_done_nxt  = 1'b1;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_pattern_nxt = r_pattern + 1'b1;
                        w_abc_nxt     = r_pattern + 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_pattern <= '0;
            r_cnt     <= '0;
            r_abc     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_table   <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pattern <= w_pattern_nxt;
            r_cnt     <= w_cnt_nxt;
            r_abc     <= w_abc_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_table   <= w_table_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    assign o_abc         = r_abc;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_table_out   = r_table;
    assign o_table_valid = r_valid;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: a default 3-input/20-cycle instance plus a
// 2-input/2-cycle instance; expected truth tables go through a scoreboard queue.
module tb_truth_table_sweeper;

    localparam int DW  = 20;
    localparam int LAT = 1 + 8 * DW;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start2;
    logic       y_in;
    logic       y2;
    logic [1:0] mode;
    int         pos;

    logic [2:0] abc;
    logic       busy, done, valid;
    logic [7:0] table_out;
    logic [1:0] abc2;
    logic       busy2, done2, valid2;
    logic [3:0] table2;

    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    truth_table_sweeper #(.N_IN(3), .DWELL(DW)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_y_in(y_in),
        .o_abc(abc), .o_busy(busy), .o_done(done),
        .o_table_out(table_out), .o_table_valid(valid)
    );

    truth_table_sweeper #(.N_IN(2), .DWELL(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_y_in(y2),
        .o_abc(abc2), .o_busy(busy2), .o_done(done2),
        .o_table_out(table2), .o_table_valid(valid2)
    );

    // Position within the current dwell window, used for the late-glitch stimulus.
    always @(posedge clk) begin
        if (busy) pos <= (pos == DW - 1) ? 0 : pos + 1;
        else      pos <= 0;
    end

    always_comb begin
        case (mode)
            2'd0:    y_in = abc[0];
            2'd1:    y_in = (abc[2] & abc[1]) | abc[0];
            2'd2:    y_in = (pos != DW - 1);
            default: y_in = 1'b0;
        endcase
    end

    assign y2 = ~abc2[1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called right after the edge that accepted start; returns in the cycle after done.
    task automatic wait_sweep(input bit jitter);
        int k;
        bit seen;
        logic [7:0] exp;
        k = 0;
        seen = 1'b0;
        while (!seen && k < LAT + 5) begin
            @(negedge clk);
            k++;
            if (jitter) start = 1'($urandom_range(0, 1));
            if (k == 1) begin
                check("busy_first", busy, 1);
                check("valid_clr", valid, 0);
            end
            if (k < LAT && (((k - 1) % DW) == 0 || (k % DW) == 0))
                check("abc_step", abc, (k - 1) / DW);
            if (done) seen = 1'b1;
        end
        if (jitter) start = 1'b0;
        check("done_latency", k, LAT);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check("table_at_done", table_out, exp);
        check("valid_at_done", valid, 1);
        check("busy_at_done", busy, 0);
        check("abc_at_done", abc, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after", busy, 0);
        check("abc_after", abc, 0);
        check("valid_hold", valid, 1);
        check("table_hold", table_out, exp);
    endtask

    initial begin
        int k;
        bit seen;
        rst    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        mode   = 2'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_abc", abc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_table", table_out, 0);
        check("rst_valid", valid, 0);
        rst = 1'b0;

        // Y = C
        mode = 2'd0;
        exp_q.push_back(8'b1010_1010);
        start_pulse();
        wait_sweep(1'b0);

        // Y = (A&B)|C
        mode = 2'd1;
        exp_q.push_back(8'b1110_1010);
        start_pulse();
        wait_sweep(1'b0);

        // Reset in the middle of pattern 011
        start_pulse();
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (abc == 3'd3) seen = 1'b1;
        end
        check("reach_abc3", seen, 1);
        check("partial_table", table_out, 8'h02);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_abc", abc, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_table", table_out, 0);
        check("midrst_valid", valid, 0);
        exp_q.push_back(8'b1110_1010);
        start_pulse();
        wait_sweep(1'b0);

        // start held high: second sweep launches from IDLE right after done
        mode = 2'd0;
        @(negedge clk);
        start = 1'b1;
        exp_q.push_back(8'b1010_1010);
        @(posedge clk);
        wait_sweep(1'b0);
        exp_q.push_back(8'b1010_1010);
        wait_sweep(1'b1);
        repeat (3) begin
            @(negedge clk);
            check("no_queued_start", busy, 0);
        end

        // Y drops only on the sampled dwell cycle
        mode = 2'd2;
        exp_q.push_back(8'h00);
        start_pulse();
        wait_sweep(1'b0);

        // N_IN=2, DWELL=2, Y = ~A
        exp_q.push_back(8'h03);
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (k <= 8) check("abc2_step", abc2, (k - 1) / 2);
            if (done2) seen = 1'b1;
        end
        check("done2_latency", k, 9);
        check("table2", {4'h0, table2}, (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx);
        check("valid2", valid2, 1);
        check("busy2", busy2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
